// File: rtl/multi_player_input_hub.sv
// multi_player_input_hub: synchronise, debounce and normalise player pins into 7-bit command words.
// Optional opposing-direction cleaning is compiled in with `define INPUT_HUB_SOCD_EN.
module multi_player_input_hub #(
   parameter int NUM_PLAYERS     = 2,
   parameter int DEBOUNCE_CYCLES = 100_000,
   parameter int CNT_W           = 17
) (
   input  logic                     clk,
   input  logic                     rst_l,
   input  logic [4*NUM_PLAYERS-1:0] dir_l,
   input  logic [2*NUM_PLAYERS-1:0] btn,
   output logic [7*NUM_PLAYERS-1:0] controller_inputs,
   output logic                     any_activity
);
   localparam int L = 6*NUM_PLAYERS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES-1);

   logic [4*NUM_PLAYERS-1:0] dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
   logic [2*NUM_PLAYERS-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [L-1:0]             norm, stable_q, stable_d;
   logic [CNT_W-1:0]         cnt_q [L];
   logic [CNT_W-1:0]         cnt_d [L];
   logic [7*NUM_PLAYERS-1:0] ci_q, ci_d;
   logic                     act_q, act_d;
   logic [5:0]               h;

   // two-stage synchroniser next state for every raw pin
   always_comb begin
      dir_s1_d = dir_l;
      dir_s2_d = dir_s1_q;
      btn_s1_d = btn;
      btn_s2_d = btn_s1_q;
   end

   // normalise to 1 = pressed, per player {shield, attack, down, up, right, left}
   always_comb begin
      norm = '0;
      for (int p = 0; p < NUM_PLAYERS; p++)
         norm[6*p +: 6] = {btn_s2_q[2*p +: 2], ~dir_s2_q[4*p +: 4]};
   end

   // debounce: count consecutive disagreeing samples, accept on the last one
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < L; i++) begin
         cnt_d[i] = '0;
         if (norm[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) stable_d[i] = norm[i];
            else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // command words: optional cleaning, attack press against the last registered attack
   always_comb begin
      ci_d = '0;
      h    = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         h = stable_q[6*p +: 6];
`ifdef INPUT_HUB_SOCD_EN
         if (h[0] && h[1]) h[1:0] = 2'b00;
         if (h[2] && h[3]) h[3]   = 1'b0;
`endif
         ci_d[7*p +: 7] = {h[4] & ~ci_q[7*p+4], h};
      end
      act_d = |stable_q;
   end

   // all state registers, cleared asynchronously to the inactive level
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         dir_s1_q <= '1;
         dir_s2_q <= '1;
         btn_s1_q <= '0;
         btn_s2_q <= '0;
         stable_q <= '0;
         for (int i = 0; i < L; i++) cnt_q[i] <= '0;
         ci_q     <= '0;
         act_q    <= 1'b0;
      end else begin
         dir_s1_q <= dir_s1_d;
         dir_s2_q <= dir_s2_d;
         btn_s1_q <= btn_s1_d;
         btn_s2_q <= btn_s2_d;
         stable_q <= stable_d;
         for (int i = 0; i < L; i++) cnt_q[i] <= cnt_d[i];
         ci_q     <= ci_d;
         act_q    <= act_d;
      end
   end

   assign controller_inputs = ci_q;
   assign any_activity      = act_q;
endmodule

// File: tb/tb_multi_player_input_hub.sv
// tb_multi_player_input_hub: randomized and directed checks against a sliding-window debounce model
module tb_multi_player_input_hub;
   localparam int N = 3, D = 4, CW = 3, L = 6*N, W = 7*N;
`ifdef INPUT_HUB_SOCD_EN
   localparam logic [1:0] LR_EXP = 2'b00;
   localparam logic [1:0] UD_EXP = 2'b01;
`else
   localparam logic [1:0] LR_EXP = 2'b11;
   localparam logic [1:0] UD_EXP = 2'b11;
`endif

   logic           clk = 1'b0;
   logic           rst_l = 1'b0;
   logic [4*N-1:0] dir_l = '1;
   logic [2*N-1:0] btn = '0;
   logic [W-1:0]   controller_inputs;
   logic           any_activity;

   int tests = 0;
   int fails = 0;

   logic [L-1:0] hist [0:D+1];
   logic [L-1:0] deb, deb_prev;
   logic [W-1:0] exp_ci;
   logic         exp_act;

   always #5 clk = ~clk;

   multi_player_input_hub #(.NUM_PLAYERS(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
      .clk(clk), .rst_l(rst_l), .dir_l(dir_l), .btn(btn),
      .controller_inputs(controller_inputs), .any_activity(any_activity)
   );

   task automatic model_reset();
      for (int d = 0; d <= D+1; d++) hist[d] = '0;
      deb = '0;
      deb_prev = '0;
      exp_ci = '0;
      exp_act = 1'b0;
   endtask

   // a line's debounced level flips once its last D synchronised samples all disagree with it
   task automatic model_edge();
      logic [5:0] hh;
      logic all_diff;
      for (int p = 0; p < N; p++) begin
         hh = deb[6*p +: 6];
`ifdef INPUT_HUB_SOCD_EN
         if (hh[0] && hh[1]) hh[1:0] = 2'b00;
         if (hh[2] && hh[3]) hh[3] = 1'b0;
`endif
         exp_ci[7*p +: 7] = {deb[6*p+4] & ~deb_prev[6*p+4], hh};
      end
      exp_act = |deb;
      deb_prev = deb;
      for (int d = D+1; d > 0; d--) hist[d] = hist[d-1];
      for (int p = 0; p < N; p++) hist[0][6*p +: 6] = {btn[2*p +: 2], ~dir_l[4*p +: 4]};
      for (int i = 0; i < L; i++) begin
         all_diff = 1'b1;
         for (int d = 2; d <= D+1; d++) if (hist[d][i] === deb[i]) all_diff = 1'b0;
         if (all_diff) deb[i] = ~deb[i];
      end
   endtask

   task automatic check(string tag);
      tests++;
      assert (controller_inputs === exp_ci) else begin
         fails++;
         $error("FAIL %s controller_inputs got %h expected %h", tag, controller_inputs, exp_ci);
      end
      tests++;
      assert (any_activity === exp_act) else begin
         fails++;
         $error("FAIL %s any_activity got %b expected %b", tag, any_activity, exp_act);
      end
   endtask

   task automatic step(string tag);
      @(posedge clk);
      if (rst_l) model_edge();
      #1;
      check(tag);
   endtask

   task automatic pulse_reset();
      rst_l = 1'b0;
      #1;
      model_reset();
      check("async_reset");
      repeat (2) @(posedge clk);
      #1 rst_l = 1'b1;
   endtask

   initial begin
      int first, press_cnt, press_at, r;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check("in_reset");
      rst_l = 1'b1;
      for (int i = 0; i < 50; i++) step("idle");

      // player 1 left: accepted on the 7th edge with activity
      dir_l[4] = 1'b0;
      first = 0;
      for (int n = 1; n <= 15; n++) begin
         step("p1_left");
         if (first == 0 && controller_inputs[7]) begin
            first = n;
            tests++;
            assert (any_activity === 1'b1) else begin
               fails++;
               $error("FAIL p1_activity got %b expected 1", any_activity);
            end
         end
      end
      tests++;
      assert (first === 7) else begin
         fails++;
         $error("FAIL p1_latency got %0d expected 7", first);
      end
      dir_l[4] = 1'b1;
      for (int i = 0; i < 12; i++) step("p1_release");

      // player 0 attack bounce then hold, twice with a release between
      for (int rep = 0; rep < 2; rep++) begin
         if (rep == 0) begin
            btn[0] = 1'b1; step("bounce");
            btn[0] = 1'b0; step("bounce");
            btn[0] = 1'b1; step("bounce");
            btn[0] = 1'b0; step("bounce");
         end
         btn[0] = 1'b1;
         first = 0;
         press_cnt = 0;
         press_at = -1;
         for (int n = 1; n <= 15; n++) begin
            step("attack_hold");
            if (first == 0 && controller_inputs[4]) first = n;
            if (controller_inputs[6]) begin
               press_cnt++;
               press_at = n;
            end
         end
         tests++;
         assert (first === 7) else begin
            fails++;
            $error("FAIL attack_latency got %0d expected 7", first);
         end
         tests++;
         assert (press_cnt === 1 && press_at === 7) else begin
            fails++;
            $error("FAIL attack_press got count %0d at %0d expected count 1 at 7", press_cnt, press_at);
         end
         btn[0] = 1'b0;
         for (int i = 0; i < 12; i++) step("attack_release");
      end

      // player 2 opposing directions
      dir_l[9:8] = 2'b00;
      for (int i = 0; i < 10; i++) step("p2_lr");
      tests++;
      assert (controller_inputs[15:14] === LR_EXP) else begin
         fails++;
         $error("FAIL p2_left_right got %b expected %b", controller_inputs[15:14], LR_EXP);
      end
      dir_l[11:10] = 2'b00;
      for (int i = 0; i < 10; i++) step("p2_ud");
      tests++;
      assert (controller_inputs[17:16] === UD_EXP) else begin
         fails++;
         $error("FAIL p2_up_down got %b expected %b", controller_inputs[17:16], UD_EXP);
      end
      dir_l = '1;
      for (int i = 0; i < 12; i++) step("p2_release");

      // reset during the 3rd debounce cycle of a pending change
      btn[1] = 1'b1;
      for (int i = 0; i < 10; i++) step("shield");
      dir_l[0] = 1'b0;
      for (int i = 0; i < 5; i++) step("pending");
      pulse_reset();
      first = 0;
      for (int n = 1; n <= 15; n++) begin
         step("post_reset");
         if (first == 0 && controller_inputs[0]) first = n;
      end
      tests++;
      assert (first === 7) else begin
         fails++;
         $error("FAIL reaccept_latency got %0d expected 7", first);
      end
      dir_l = '1;
      btn = '0;
      for (int i = 0; i < 12; i++) step("quiet");

      // randomized toggling, sparse then dense, with one reset in the middle
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, (i < 750) ? 3 : 0) == 0) begin
            r = $urandom_range(0, L-1);
            if (r < 4*N) dir_l[r] = ~dir_l[r];
            else         btn[r-4*N] = ~btn[r-4*N];
         end
         if (i == 1000) pulse_reset();
         else step("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
